// File: rtl/cam_frame_seq_if.sv
// cam_frame_seq_if
// Bundles the control, camera and packer-side signals of the frame capture
// sequencer so the sequencer and whatever drives it share one port.
//   master : drives start/abort/frame_num and the raw camera timing inputs,
//            observes the write gate, counters and status pulses.
//   slave  : the sequencer itself (mirror image of master).
// Signals:
//   start, abort     single-cycle command strobes
//   frame_num[7:0]   frames to capture, 0 = continuous
//   cam_vsync        camera vsync (rising edge = frame boundary)
//   cam_href         camera line-valid
//   wr_en            pixel write gate to the packer
//   pix_cnt[CW-1:0]  pixel index within the current line
//   line_cnt[CW-1:0] completed lines in the current frame
//   frame_start      one-cycle pulse, a capture frame begins
//   frame_done       one-cycle pulse, a captured frame ended
//   frame_err        one-cycle pulse with frame_done on geometry mismatch
//   frames_cap[7:0]  frames completed since the last accepted start
//   busy             sequencer not idle
interface cam_frame_seq_if #(
    parameter int CW = 12
);
    logic          start;
    logic          abort;
    logic [7:0]    frame_num;
    logic          cam_vsync;
    logic          cam_href;
    logic          wr_en;
    logic [CW-1:0] pix_cnt;
    logic [CW-1:0] line_cnt;
    logic          frame_start;
    logic          frame_done;
    logic          frame_err;
    logic [7:0]    frames_cap;
    logic          busy;

    modport master (
        output start, abort, frame_num, cam_vsync, cam_href,
        input  wr_en, pix_cnt, line_cnt, frame_start, frame_done, frame_err,
               frames_cap, busy
    );

    modport slave (
        input  start, abort, frame_num, cam_vsync, cam_href,
        output wr_en, pix_cnt, line_cnt, frame_start, frame_done, frame_err,
               frames_cap, busy
    );
endinterface

// File: rtl/cam_frame_seq.sv
// cam_frame_seq
// Frame capture sequencer for the OV5640 input path. cam_vsync/cam_href are
// brought into clk with two flops each, and their edges are taken from the
// two flop outputs. After start the sequencer throws away SKIP_FRAMES whole
// frames while exposure settles, then gates pixels to the packer for
// frame_num frames (or forever when frame_num is 0), checking each frame's
// geometry against H_PIXELS x V_LINES.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    cam_frame_seq_if.slave (commands, camera timing, gate, counters,
//          status pulses)
module cam_frame_seq #(
    parameter int SKIP_FRAMES = 10,
    parameter int H_PIXELS    = 640,
    parameter int V_LINES     = 480,
    parameter int CW          = 12
) (
    input logic            clk,
    input logic            rst_n,
    cam_frame_seq_if.slave bus
);
    localparam int SW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CAPTURE
    } state_e;

    state_e        state_q, state_d;
    logic          vs_r1_q, vs_r2_q, hr_r1_q, hr_r2_q;
    logic [7:0]    target_q, target_d;
    logic [7:0]    frames_cap_q, frames_cap_d;
    logic [SW-1:0] skip_cnt_q, skip_cnt_d;
    logic [CW-1:0] pix_cnt_q, pix_cnt_d;
    logic [CW-1:0] line_cnt_q, line_cnt_d;
    logic          err_flag_q, err_flag_d;
    logic          line_open_q, line_open_d;
    logic          frame_start_q, frame_start_d;
    logic          frame_done_q, frame_done_d;
    logic          frame_err_q, frame_err_d;

    logic vs_rise, hr_rise, hr_fall, in_cap, wr_en;

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        vs_rise       = vs_r1_q & ~vs_r2_q;
        hr_rise       = hr_r1_q & ~hr_r2_q;
        hr_fall       = ~hr_r1_q & hr_r2_q;
        in_cap        = (state_q == S_CAPTURE);
        wr_en         = in_cap & hr_r2_q;

        state_d       = state_q;
        target_d      = target_q;
        frames_cap_d  = frames_cap_q;
        skip_cnt_d    = skip_cnt_q;
        pix_cnt_d     = pix_cnt_q;
        line_cnt_d    = line_cnt_q;
        err_flag_d    = err_flag_q;
        line_open_d   = line_open_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        frame_err_d   = 1'b0;

        // Pixel counter: restarts with each line, counts gated pixels.
        if (hr_rise) begin
            pix_cnt_d = '0;
        end else if (wr_en && (pix_cnt_q != '1)) begin
            pix_cnt_d = pix_cnt_q + 1'b1;
        end

        // Only lines that began inside the capture frame are counted and
        // checked. The length check uses pix_cnt_d so the final pixel of the
        // line (gated in this same cycle) is included.
        if (in_cap) begin
            if (hr_rise) begin
                line_open_d = 1'b1;
            end else if (hr_fall && line_open_q) begin
                line_open_d = 1'b0;
                if (line_cnt_q != '1) begin
                    line_cnt_d = line_cnt_q + 1'b1;
                end
                if (pix_cnt_d != CW'(H_PIXELS)) begin
                    err_flag_d = 1'b1;
                end
            end
        end

        if (bus.abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_d      = S_WAIT;
                        target_d     = bus.frame_num;
                        skip_cnt_d   = '0;
                        frames_cap_d = '0;
                        pix_cnt_d    = '0;
                        line_cnt_d   = '0;
                        err_flag_d   = 1'b0;
                        line_open_d  = 1'b0;
                    end
                end
                S_WAIT: begin
                    if (vs_rise) begin
                        if (skip_cnt_q == SW'(SKIP_FRAMES)) begin
                            state_d       = S_CAPTURE;
                            frame_start_d = 1'b1;
                            pix_cnt_d     = '0;
                            line_cnt_d    = '0;
                            err_flag_d    = 1'b0;
                            line_open_d   = hr_rise;
                        end else begin
                            skip_cnt_d = skip_cnt_q + 1'b1;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (vs_rise) begin
                        // Uses the _d values so a line ending in this very
                        // cycle is already counted and checked.
                        frame_done_d = 1'b1;
                        frame_err_d  = err_flag_d | (line_cnt_d != CW'(V_LINES));
                        frames_cap_d = frames_cap_q + 8'd1;
                        if ((target_q != 8'd0) && (frames_cap_q + 8'd1 == target_q)) begin
                            state_d = S_IDLE;
                        end else begin
                            frame_start_d = 1'b1;
                            pix_cnt_d     = '0;
                            line_cnt_d    = '0;
                            err_flag_d    = 1'b0;
                            line_open_d   = hr_rise;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            vs_r1_q       <= 1'b0;
            vs_r2_q       <= 1'b0;
            hr_r1_q       <= 1'b0;
            hr_r2_q       <= 1'b0;
            target_q      <= '0;
            frames_cap_q  <= '0;
            skip_cnt_q    <= '0;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            err_flag_q    <= 1'b0;
            line_open_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            vs_r1_q       <= bus.cam_vsync;
            vs_r2_q       <= vs_r1_q;
            hr_r1_q       <= bus.cam_href;
            hr_r2_q       <= hr_r1_q;
            target_q      <= target_d;
            frames_cap_q  <= frames_cap_d;
            skip_cnt_q    <= skip_cnt_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            err_flag_q    <= err_flag_d;
            line_open_q   <= line_open_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            frame_err_q   <= frame_err_d;
        end
    end

    // wr_en and busy decode flops only; no camera input reaches them
    // combinationally.
    assign bus.wr_en       = wr_en;
    assign bus.pix_cnt     = pix_cnt_q;
    assign bus.line_cnt    = line_cnt_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.frames_cap  = frames_cap_q;
    assign bus.busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_cam_frame_seq.sv
// tb_cam_frame_seq
// Scenario bench for cam_frame_seq with a small geometry (skip 2, 8x4).
// Inputs change 1 ns after a rising edge; a monitor samples outputs on the
// falling edge and keeps running tallies that each scenario compares, as
// deltas, against values worked out from the frame rules.
module tb_cam_frame_seq;
    localparam int SKIP = 2;
    localparam int H    = 8;
    localparam int V    = 4;
    localparam int CW   = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    cam_frame_seq_if #(.CW(CW)) bus ();

    cam_frame_seq #(
        .SKIP_FRAMES(SKIP),
        .H_PIXELS   (H),
        .V_LINES    (V),
        .CW         (CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Monitor tallies (sole writer is the monitor process).
    int wr_cnt    = 0;
    int wr_rises  = 0;
    int lat_bad   = 0;
    int n_start   = 0;
    int n_done    = 0;
    int n_err     = 0;
    int n_coinc   = 0;
    bit err_log [256];
    bit h1 = 1'b0, h2 = 1'b0, h3 = 1'b0, wr_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.wr_en) wr_cnt++;
        // A gate rise must follow an href rise seen two samples earlier.
        if (bus.wr_en && !wr_prev) begin
            wr_rises++;
            if (!(h2 && !h3)) lat_bad++;
        end
        if (bus.frame_start) n_start++;
        if (bus.frame_done) begin
            err_log[n_done[7:0]] = bus.frame_err;
            n_done++;
        end
        if (bus.frame_err) n_err++;
        if (bus.frame_done && bus.frame_start) n_coinc++;
        h3      = h2;
        h2      = h1;
        h1      = bus.cam_href;
        wr_prev = bus.wr_en;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int fn);
        bus.frame_num = 8'(fn);
        bus.start     = 1'b1;
        tick(1);
        bus.start     = 1'b0;
    endtask

    task automatic do_abort();
        bus.abort = 1'b1;
        tick(1);
        bus.abort = 1'b0;
    endtask

    task automatic vs_edge();
        bus.cam_vsync = 1'b1;
        tick(2);
        bus.cam_vsync = 1'b0;
        tick(3);
    endtask

    task automatic send_line(input int len);
        bus.cam_href = 1'b1;
        tick(len);
        bus.cam_href = 1'b0;
        tick(3);
    endtask

    task automatic send_clean_body();
        for (int l = 0; l < V; l++) send_line(H);
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.abort = 1'b0; bus.frame_num = 8'd0;
        bus.cam_vsync = 1'b0; bus.cam_href = 1'b0;
        rst_n = 1'b0;
        tick(3);
        n_checks++;
        if ({bus.wr_en, bus.frame_start, bus.frame_done, bus.frame_err, bus.busy,
             bus.pix_cnt, bus.line_cnt, bus.frames_cap} !== '0)
            $display("FAIL reset_outputs: actual wr=%b fs=%b fd=%b fe=%b busy=%b pix=%0d line=%0d cap=%0d required all zero",
                     bus.wr_en, bus.frame_start, bus.frame_done, bus.frame_err, bus.busy,
                     bus.pix_cnt, bus.line_cnt, bus.frames_cap);
        else n_pass++;
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_single_frame();
        int b_wr = wr_cnt, b_st = n_start, b_dn = n_done, b_er = n_err;
        int b_rise = wr_rises, b_lat = lat_bad;
        do_start(1);
        n_checks++;
        if (bus.busy !== 1'b1) $display("FAIL t1_busy_after_start: actual=%b required=1", bus.busy);
        else n_pass++;
        for (int f = 0; f < 4; f++) begin
            vs_edge();
            if (f == 1) begin
                n_checks++;
                if (n_start - b_st !== 0)
                    $display("FAIL t1_skip_no_start: actual=%0d required=0", n_start - b_st);
                else n_pass++;
            end
            if (f < 3) send_clean_body();
        end
        tick(2);
        n_checks++;
        if (n_start - b_st !== 1) $display("FAIL t1_frame_start: actual=%0d required=1", n_start - b_st);
        else n_pass++;
        n_checks++;
        if (wr_cnt - b_wr !== V * H) $display("FAIL t1_wr_cycles: actual=%0d required=%0d", wr_cnt - b_wr, V * H);
        else n_pass++;
        n_checks++;
        if ((wr_rises - b_rise !== V) || (lat_bad - b_lat !== 0))
            $display("FAIL t1_wr_latency: actual rises=%0d bad=%0d required rises=%0d bad=0",
                     wr_rises - b_rise, lat_bad - b_lat, V);
        else n_pass++;
        n_checks++;
        if ((n_done - b_dn !== 1) || (n_err - b_er !== 0))
            $display("FAIL t1_done_err: actual done=%0d err=%0d required done=1 err=0", n_done - b_dn, n_err - b_er);
        else n_pass++;
        n_checks++;
        if ({bus.busy, bus.frames_cap, bus.line_cnt, bus.pix_cnt} !== {1'b0, 8'd1, CW'(V), CW'(H)})
            $display("FAIL t1_final_state: actual busy=%b cap=%0d line=%0d pix=%0d required busy=0 cap=1 line=%0d pix=%0d",
                     bus.busy, bus.frames_cap, bus.line_cnt, bus.pix_cnt, V, H);
        else n_pass++;
    endtask

    task automatic test_short_line();
        int b_dn = n_done, b_er = n_err, b_wr = wr_cnt;
        do_start(1);
        for (int f = 0; f < SKIP + 1; f++) vs_edge();
        for (int l = 0; l < V; l++) send_line((l == 2) ? H - 1 : H);
        vs_edge();
        tick(2);
        n_checks++;
        if ((n_done - b_dn !== 1) || (n_err - b_er !== 1) || (err_log[b_dn[7:0]] !== 1'b1))
            $display("FAIL t2_short_line_err: actual done=%0d err=%0d required done=1 err=1 (coincident)",
                     n_done - b_dn, n_err - b_er);
        else n_pass++;
        n_checks++;
        if ((bus.line_cnt !== CW'(V)) || (wr_cnt - b_wr !== V * H - 1))
            $display("FAIL t2_line_cnt: actual line=%0d wr=%0d required line=%0d wr=%0d",
                     bus.line_cnt, wr_cnt - b_wr, V, V * H - 1);
        else n_pass++;
    endtask

    task automatic test_continuous();
        int b_dn = n_done, b_co = n_coinc, b_er = n_err;
        do_start(0);
        for (int f = 0; f < SKIP + 1; f++) vs_edge();
        for (int f = 0; f < 5; f++) begin
            send_clean_body();
            vs_edge();
        end
        tick(2);
        n_checks++;
        if ((n_done - b_dn !== 5) || (n_coinc - b_co !== 5) || (n_err - b_er !== 0))
            $display("FAIL t3_continuous_pulses: actual done=%0d coinc=%0d err=%0d required 5 5 0",
                     n_done - b_dn, n_coinc - b_co, n_err - b_er);
        else n_pass++;
        n_checks++;
        if ((bus.busy !== 1'b1) || (bus.frames_cap !== 8'd5))
            $display("FAIL t3_busy_cap: actual busy=%b cap=%0d required busy=1 cap=5", bus.busy, bus.frames_cap);
        else n_pass++;
        do_abort();
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL t3_abort_idle: actual busy=%b required=0", bus.busy);
        else n_pass++;
    endtask

    task automatic test_abort();
        int b_dn = n_done, b_st;
        do_start(1);
        for (int f = 0; f < SKIP + 1; f++) vs_edge();
        bus.cam_href = 1'b1;
        tick(4);
        n_checks++;
        if (bus.wr_en !== 1'b1) $display("FAIL t4_wr_before_abort: actual=%b required=1", bus.wr_en);
        else n_pass++;
        do_abort();
        n_checks++;
        if ({bus.wr_en, bus.busy} !== 2'b00)
            $display("FAIL t4_after_abort: actual wr=%b busy=%b required wr=0 busy=0", bus.wr_en, bus.busy);
        else n_pass++;
        tick(4);
        bus.cam_href = 1'b0;
        tick(3);
        vs_edge();
        n_checks++;
        if (n_done - b_dn !== 0) $display("FAIL t4_no_done: actual=%0d required=0", n_done - b_dn);
        else n_pass++;
        b_st = n_start;
        do_start(1);
        for (int f = 0; f < SKIP; f++) vs_edge();
        n_checks++;
        if (n_start - b_st !== 0) $display("FAIL t4_restart_skips: actual=%0d required=0", n_start - b_st);
        else n_pass++;
        vs_edge();
        n_checks++;
        if (n_start - b_st !== 1) $display("FAIL t4_restart_capture: actual=%0d required=1", n_start - b_st);
        else n_pass++;
        do_abort();
    endtask

    task automatic test_start_conflicts();
        int b_dn = n_done;
        bus.frame_num = 8'd1;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick(1);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        tick(1);
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL t5_abort_beats_start: actual busy=%b required=0", bus.busy);
        else n_pass++;
        do_start(1);
        for (int f = 0; f < SKIP + 1; f++) vs_edge();
        do_start(3);
        send_clean_body();
        vs_edge();
        tick(1);
        n_checks++;
        if ((n_done - b_dn !== 1) || (bus.busy !== 1'b0) || (bus.frames_cap !== 8'd1))
            $display("FAIL t5_start_ignored: actual done=%0d busy=%b cap=%0d required done=1 busy=0 cap=1",
                     n_done - b_dn, bus.busy, bus.frames_cap);
        else n_pass++;
    endtask

    // Reference: a frame is good only with exactly V lines of exactly H
    // pixels; every href cycle of a captured frame is one gated pixel.
    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int fn;
            int exp_wr;
            bit exp_err [3];
            int b_wr;
            int b_dn;
            fn     = int'($urandom_range(1, 3));
            exp_wr = 0;
            b_wr   = wr_cnt;
            b_dn   = n_done;
            do_start(fn);
            for (int s = 0; s < SKIP; s++) begin
                vs_edge();
                send_line(int'($urandom_range(3, 10)));
            end
            for (int f = 0; f < fn; f++) begin
                int nl;
                vs_edge();
                nl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 5)) : V;
                exp_err[f] = (nl != V);
                for (int l = 0; l < nl; l++) begin
                    int len;
                    len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(6, 9)) : H;
                    if (len != H) exp_err[f] = 1'b1;
                    exp_wr += len;
                    send_line(len);
                end
            end
            vs_edge();
            tick(1);
            n_checks++;
            if ((n_done - b_dn !== fn) || (bus.frames_cap !== 8'(fn)) || (bus.busy !== 1'b0))
                $display("FAIL rnd%0d_frames: actual done=%0d cap=%0d busy=%b required done=%0d cap=%0d busy=0",
                         it, n_done - b_dn, bus.frames_cap, bus.busy, fn, fn);
            else n_pass++;
            n_checks++;
            if (wr_cnt - b_wr !== exp_wr)
                $display("FAIL rnd%0d_wr_cycles: actual=%0d required=%0d", it, wr_cnt - b_wr, exp_wr);
            else n_pass++;
            for (int f = 0; f < fn; f++) begin
                n_checks++;
                if (err_log[8'(b_dn + f)] !== exp_err[f])
                    $display("FAIL rnd%0d_err_f%0d: actual=%b required=%b", it, f, err_log[8'(b_dn + f)], exp_err[f]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_edge_coincide_and_reset();
        int b_dn = n_done, b_er = n_err;
        do_start(1);
        for (int f = 0; f < SKIP + 1; f++) vs_edge();
        for (int l = 0; l < V - 1; l++) send_line(H);
        // Last line: href falls in the same clk vsync rises.
        bus.cam_href = 1'b1;
        tick(H);
        bus.cam_href  = 1'b0;
        bus.cam_vsync = 1'b1;
        tick(2);
        bus.cam_vsync = 1'b0;
        tick(3);
        n_checks++;
        if ((n_done - b_dn !== 1) || (n_err - b_er !== 0) || (bus.line_cnt !== CW'(V)))
            $display("FAIL t6_coincident_edges: actual done=%0d err=%0d line=%0d required done=1 err=0 line=%0d",
                     n_done - b_dn, n_err - b_er, bus.line_cnt, V);
        else n_pass++;
        b_dn = n_done;
        do_start(0);
        for (int f = 0; f < SKIP + 1; f++) vs_edge();
        bus.cam_href = 1'b1;
        tick(4);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.wr_en, bus.frame_start, bus.frame_done, bus.frame_err, bus.busy,
             bus.pix_cnt, bus.line_cnt, bus.frames_cap} !== '0)
            $display("FAIL t6_reset_midframe: actual wr=%b busy=%b pix=%0d cap=%0d required all zero",
                     bus.wr_en, bus.busy, bus.pix_cnt, bus.frames_cap);
        else n_pass++;
        bus.cam_href = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        n_checks++;
        if ((n_done - b_dn !== 0) || (bus.busy !== 1'b0))
            $display("FAIL t6_reset_no_status: actual done=%0d busy=%b required done=0 busy=0", n_done - b_dn, bus.busy);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_short_line();
        test_continuous();
        test_abort();
        test_start_conflicts();
        test_random();
        test_edge_coincide_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cam_frame_seq.md
Name: cam_frame_seq

Overview:
- Frame capture sequencer for the OV5640 input path.
- Synchronises cam_vsync/cam_href into clk and detects their edges internally with a 2-register scheme.
- After a start command, discards the first SKIP_FRAMES frames while sensor exposure settles, then captures a programmed number of frames (or runs continuously).
- Drives the write-enable gate, pixel/line counters and per-frame status pulses for the downstream pixel packer and FIFO writer.

Parameters:
- SKIP_FRAMES, 10, whole frames discarded after start before capture (0 allowed)
- H_PIXELS, 640, expected wr_en cycles per line
- V_LINES, 480, expected lines per frame
- CW, 12, width of pix_cnt/line_cnt (must hold H_PIXELS and V_LINES)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- start  in  1  single-cycle capture request
- abort  in  1  single-cycle stop request
- frame_num  in  8  frames to capture, sampled on accepted start; 0 = continuous
- cam_vsync  in  1  camera vsync; rising edge = frame boundary
- cam_href  in  1  camera line-valid
- wr_en  out  1  pixel write gate to the packer
- pix_cnt  out  CW  pixel index within the current line
- line_cnt  out  CW  completed lines in the current frame
- frame_start  out  1  one-cycle pulse: a capture frame begins
- frame_done  out  1  one-cycle pulse: a captured frame ended
- frame_err  out  1  one-cycle pulse, coincident with frame_done, on geometry mismatch
- frames_cap  out  8  frames completed since the last accepted start
- busy  out  1  state != IDLE

Behaviour:
- Reset: clk, rst_n asynchronous, active-low.
  - All registers clear; state = IDLE.
  - Outputs on reset: wr_en, frame_start, frame_done, frame_err, busy = 0; pix_cnt, line_cnt, frames_cap = 0.
  - Reset mid-frame aborts with no status pulse.
- Sync and edge detection: vs_r1 <= cam_vsync, vs_r2 <= vs_r1; same scheme for href (hr_r1, hr_r2).
  - vs_rise = vs_r1 & ~vs_r2.
  - hr_rise = hr_r1 & ~hr_r2.
  - hr_fall = ~hr_r1 & hr_r2.
  - Edge pulses appear 2 clk after the input transition.
- State machine:
  - IDLE:
    - On start & ~abort: latch frame_num into target; clear skip_cnt, frames_cap and the counters; go to WAIT.
    - start is ignored in any other state.
  - WAIT, on vs_rise:
    - If skip_cnt == SKIP_FRAMES: go to CAPTURE, pulse frame_start, clear pix_cnt, line_cnt and err_flag.
    - Otherwise skip_cnt++.
    - The partial frame in progress when start is accepted is never counted.
  - CAPTURE, on vs_rise (end of frame):
    - Pulse frame_done; set frame_err = err_flag | (line_cnt != V_LINES); frames_cap++.
    - If target != 0 and frames_cap+1 == target: go to IDLE.
    - Otherwise stay in CAPTURE: pulse frame_start in the same cycle and clear the counters and err_flag.
  - abort (any state): go to IDLE on the next edge; no frame_done/frame_err; abort beats start.
- wr_en = (state == CAPTURE) & hr_r2, registered-source with no combinational input path. Latency from cam_href is 2 clk.
- pix_cnt:
  - Clears on hr_rise.
  - Increments in every cycle with wr_en = 1.
  - Holds otherwise.
  - Saturates at all-ones.
- line_cnt:
  - Increments on hr_fall in CAPTURE.
  - Saturates.
  - On the same hr_fall, if pix_cnt != H_PIXELS, sets the sticky err_flag.
- Simultaneous hr_fall and vs_rise: the line is counted and checked first, and the end-of-frame check uses the updated values.
- A line open when capture starts (hr_r2 = 1 at the frame_start cycle) is not counted: line_cnt/err updates are qualified by a line_open flag set on hr_rise in CAPTURE.
- frames_cap wraps at 255 in continuous mode.
- busy asserts the cycle after an accepted start and deasserts the cycle after the final frame_done or abort.

Test Plan:
1. SKIP_FRAMES=2, H_PIXELS=8, V_LINES=4, frame_num=1; start, then 4 clean frames of 4×8 href cycles -> vs_rise #1,#2 skipped; frame_start on vs_rise #3; wr_en high for exactly 32 cycles, each rising 2 clk after cam_href; frame_done=1, frame_err=0 at vs_rise #4; frames_cap=1; busy falls.
2. Same setup, one line only 7 href cycles -> frame_done and frame_err both pulse at frame end; line_cnt=4.
3. frame_num=0, 5 frames after skip -> 5 frame_done pulses, each coincident with frame_start; busy stays 1; frames_cap=5.
4. abort during a line in CAPTURE -> wr_en=0 next cycle; no frame_done; state IDLE; a new start restarts skipping from 0.
5. start and abort asserted together in IDLE -> stay IDLE, busy=0. start asserted during CAPTURE -> ignored, target unchanged.
6. cam_href falls in the same clk as cam_vsync rises on the last line (line 4) -> line_cnt counted to 4 before the check; frame_err=0. Also assert rst_n mid-frame -> all outputs 0 immediately.
